// File: rtl/pid_sched.sv
// Scheduler that time-multiplexes one PID compute core across NCH channels.
// A periodic tick starts an ascending scan of the enabled channels; results are republished per channel.
module pid_sched #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int TICK_DIV = 1000,
    parameter int TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NCH)-1:0]     cfg_ch,
    input  logic signed [DW-1:0]       cfg_kp,
    input  logic signed [DW-1:0]       cfg_ki,
    input  logic [NCH-1:0]             ch_en,
    input  logic [NCH*DW-1:0]          ref_i,
    input  logic [NCH*DW-1:0]          meas_i,
    output logic                       pid_start,
    output logic [$clog2(NCH)-1:0]     pid_ch,
    output logic signed [DW-1:0]       pid_ref,
    output logic signed [DW-1:0]       pid_meas,
    output logic signed [DW-1:0]       pid_kp,
    output logic signed [DW-1:0]       pid_ki,
    input  logic                       pid_done,
    input  logic signed [DW-1:0]       pid_out,
    output logic                       out_valid,
    output logic [$clog2(NCH)-1:0]     out_ch,
    output logic signed [DW-1:0]       out_val,
    output logic                       busy,
    output logic                       overrun,
    output logic [NCH-1:0]             fault,
    input  logic                       err_clr
);

    localparam int CW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int KW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [KW-1:0]         r_tick_cnt;
    logic                  w_tick;

    logic [NCH-1:0]        r_mask;
    logic [CW-1:0]         r_sel;
    logic [CW-1:0]         w_low;
    logic [TW-1:0]         r_tmo_cnt;

    logic signed [DW-1:0]  r_kp [NCH];
    logic signed [DW-1:0]  r_ki [NCH];
    logic [DW-1:0]         w_ref  [NCH];
    logic [DW-1:0]         w_meas [NCH];
    logic                  w_cfg_ok;

    logic                  r_pid_start;
    logic [CW-1:0]         r_pid_ch;
    logic signed [DW-1:0]  r_pid_ref;
    logic signed [DW-1:0]  r_pid_meas;
    logic signed [DW-1:0]  r_pid_kp;
    logic signed [DW-1:0]  r_pid_ki;
    logic                  r_out_valid;
    logic [CW-1:0]         r_out_ch;
    logic signed [DW-1:0]  r_out_val;
    logic                  r_overrun;
    logic [NCH-1:0]        r_fault;

    logic                  w_busy;
    logic                  w_latch;
    logic                  w_sel;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_ovr_set;

    // Sample tick: asserted in the cycle the counter wraps back to zero.
    assign w_tick = (r_tick_cnt == KW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + KW'(1);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            w_ref[k]  = ref_i[k*DW +: DW];
            w_meas[k] = meas_i[k*DW +: DW];
        end
    end

    always_comb begin
        w_low = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (r_mask[i-1]) begin
                w_low = CW'(i - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A done in the final WAIT cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick && (ch_en != '0)) w_state_nxt = S_SCAN;
            S_SCAN:  w_state_nxt = (r_mask == '0) ? S_IDLE : S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (pid_done || (r_tmo_cnt == TW'(1))) w_state_nxt = S_SCAN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_latch   = (r_state == S_IDLE) && w_tick;
        w_sel     = (r_state == S_SCAN);
        w_issue   = (r_state == S_ISSUE);
        w_done    = (r_state == S_WAIT) && pid_done;
        w_timeout = (r_state == S_WAIT) && !pid_done && (r_tmo_cnt == TW'(1));
        w_ovr_set = (r_state != S_IDLE) && w_tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask    <= '0;
            r_sel     <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_mask <= ch_en;
            end
            if (w_sel) begin
                r_sel <= w_low;
            end
            if (w_issue) begin
                r_mask[r_sel] <= 1'b0;
                r_tmo_cnt     <= TW'(TIMEOUT);
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt - TW'(1);
            end
        end
    end

    // Operands read the bank before a same-edge write lands, so ISSUE sees old gains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pid_start <= 1'b0;
            r_pid_ch    <= '0;
            r_pid_ref   <= '0;
            r_pid_meas  <= '0;
            r_pid_kp    <= '0;
            r_pid_ki    <= '0;
        end else begin
            r_pid_start <= w_issue;
            if (w_issue) begin
                r_pid_ch   <= r_sel;
                r_pid_ref  <= w_ref[r_sel];
                r_pid_meas <= w_meas[r_sel];
                r_pid_kp   <= r_kp[r_sel];
                r_pid_ki   <= r_ki[r_sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_val   <= '0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                r_out_ch  <= r_pid_ch;
                r_out_val <= pid_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_fault   <= '0;
        end else if (err_clr) begin
            r_overrun <= 1'b0;
            r_fault   <= '0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_timeout) begin
                r_fault[r_pid_ch] <= 1'b1;
            end
        end
    end

    assign w_cfg_ok = cfg_we && (int'(cfg_ch) < NCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                r_kp[k] <= '0;
                r_ki[k] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_kp[cfg_ch] <= cfg_kp;
            r_ki[cfg_ch] <= cfg_ki;
        end
    end

    assign pid_start = r_pid_start;
    assign pid_ch    = r_pid_ch;
    assign pid_ref   = r_pid_ref;
    assign pid_meas  = r_pid_meas;
    assign pid_kp    = r_pid_kp;
    assign pid_ki    = r_pid_ki;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_val   = r_out_val;
    assign busy      = w_busy;
    assign overrun   = r_overrun;
    assign fault     = r_fault;

endmodule

// File: tb/tb_pid_sched.sv
// Bench for pid_sched: directed scenarios plus randomized traffic, checked against a
// schedule model that computes issue/result/fault cycles arithmetically at each tick.
module tb_pid_sched;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int TD  = 40;
    localparam int TMO = 16;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CW-1:0]     cfg_ch = '0;
    logic [DW-1:0]     cfg_kp = '0;
    logic [DW-1:0]     cfg_ki = '0;
    logic [NCH-1:0]    ch_en = '0;
    logic [NCH*DW-1:0] ref_i = '0;
    logic [NCH*DW-1:0] meas_i = '0;
    logic              pid_done = 1'b0;
    logic [DW-1:0]     pid_out = '0;
    logic              err_clr = 1'b0;
    logic              pid_start;
    logic [CW-1:0]     pid_ch;
    logic [DW-1:0]     pid_ref, pid_meas, pid_kp, pid_ki;
    logic              out_valid;
    logic [CW-1:0]     out_ch;
    logic [DW-1:0]     out_val;
    logic              busy;
    logic              overrun;
    logic [NCH-1:0]    fault;

    always #5 clk = ~clk;

    pid_sched #(.NCH(NCH), .DW(DW), .TICK_DIV(TD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_kp(cfg_kp), .cfg_ki(cfg_ki),
        .ch_en(ch_en), .ref_i(ref_i), .meas_i(meas_i), .pid_start(pid_start), .pid_ch(pid_ch),
        .pid_ref(pid_ref), .pid_meas(pid_meas), .pid_kp(pid_kp), .pid_ki(pid_ki),
        .pid_done(pid_done), .pid_out(pid_out), .out_valid(out_valid), .out_ch(out_ch),
        .out_val(out_val), .busy(busy), .overrun(overrun), .fault(fault), .err_clr(err_clr)
    );

    // One planned channel computation: start cycle, core latency, captured operands, result.
    typedef struct {
        int            ch;
        int            s;
        int            lat;
        bit            ok;
        int            w;
        logic [DW-1:0] rv, mv, kp, ki, res;
    } plan_t;

    plan_t          plan[$];
    logic [DW-1:0]  m_kp [NCH];
    logic [DW-1:0]  m_ki [NCH];
    logic           m_ovr;
    logic [NCH-1:0] m_fault;
    int             m_lo, m_hi;
    int             cyc;
    int             n_checks = 0;
    int             n_err = 0;

    bit             rst_drv, rand_mode, fix_ref, race_mode, done_force, err_drv, wr_drv, last_tick;
    logic [NCH-1:0] en_drv;
    int             lat_tab [NCH];
    logic [CW-1:0]  wr_ch;
    logic [DW-1:0]  wr_kp, wr_ki, race_kp, race_ki;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_kp[i] = '0;
            m_ki[i] = '0;
        end
        plan.delete();
        m_ovr   = 1'b0;
        m_fault = '0;
        m_lo    = 1;
        m_hi    = 0;
        cyc     = 0;
    endtask

    function automatic int pick_lat();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return TMO - 1;
            4:       return TMO;
            5:       return TMO + 3;
            default: return int'($urandom_range(3, 10));
        endcase
    endfunction

    task automatic step();
        bit e_start, e_valid, tick, dn, in_wait, busy_now;
        int ps, pv, s, lat;
        @(negedge clk);
        e_start = 0; e_valid = 0; ps = 0; pv = 0;
        foreach (plan[i]) begin
            if (plan[i].s == cyc) begin e_start = 1; ps = i; end
            if (plan[i].ok && (plan[i].s + plan[i].lat + 1 == cyc)) begin e_valid = 1; pv = i; end
        end
        check_eq("pid_start", 32'(pid_start), 32'(e_start));
        check_eq("busy", 32'(busy), 32'((cyc >= m_lo) && (cyc <= m_hi)));
        check_eq("out_valid", 32'(out_valid), 32'(e_valid));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        check_eq("fault", 32'(fault), 32'(m_fault));
        if (e_start) begin
            check_eq("pid_ch", 32'(pid_ch), 32'(plan[ps].ch));
            check_eq("pid_ref", 32'(pid_ref), 32'(plan[ps].rv));
            check_eq("pid_meas", 32'(pid_meas), 32'(plan[ps].mv));
            check_eq("pid_kp", 32'(pid_kp), 32'(plan[ps].kp));
            check_eq("pid_ki", 32'(pid_ki), 32'(plan[ps].ki));
        end
        if (e_valid) begin
            check_eq("out_ch", 32'(out_ch), 32'(plan[pv].ch));
            check_eq("out_val", 32'(out_val), 32'(plan[pv].res));
        end

        // Drive this cycle's inputs.
        rst   = rst_drv;
        tick  = ((cyc % TD) == TD - 1);
        ch_en = rand_mode ? NCH'($urandom) : en_drv;
        if (fix_ref) begin
            ref_i  = {NCH{DW'(40)}};
            meas_i = {NCH{DW'(25)}};
        end else begin
            ref_i  = (NCH*DW)'($urandom);
            meas_i = (NCH*DW)'($urandom);
        end
        dn = done_force; in_wait = 0;
        foreach (plan[i]) begin
            if (plan[i].ok && (plan[i].s + plan[i].lat == cyc)) dn = 1;
            if ((cyc >= plan[i].s) && (cyc < plan[i].s + plan[i].w)) in_wait = 1;
        end
        if (rand_mode && !in_wait && ($urandom_range(0, 7) == 0)) dn = 1;
        pid_done = dn;
        pid_out  = DW'($urandom);
        cfg_we   = 1'b0;
        if (wr_drv) begin
            cfg_we = 1'b1; cfg_ch = wr_ch; cfg_kp = wr_kp; cfg_ki = wr_ki;
        end else if (race_mode) begin
            foreach (plan[i]) begin
                if ((plan[i].s - 1 == cyc) && (plan[i].ch == 0)) begin
                    cfg_we = 1'b1; cfg_ch = '0; cfg_kp = race_kp; cfg_ki = race_ki;
                end
            end
        end else if (rand_mode && ($urandom_range(0, 5) == 0)) begin
            cfg_we = 1'b1; cfg_ch = CW'($urandom); cfg_kp = DW'($urandom); cfg_ki = DW'($urandom);
        end
        err_clr = err_drv || (rand_mode && ($urandom_range(0, 19) == 0));

        // Advance the model across the coming edge.
        if (rst_drv) begin
            model_reset();
            last_tick = 0;
            return;
        end
        foreach (plan[i]) begin
            if (plan[i].s - 1 == cyc) begin
                plan[i].rv = ref_i[plan[i].ch*DW +: DW];
                plan[i].mv = meas_i[plan[i].ch*DW +: DW];
                plan[i].kp = m_kp[plan[i].ch];
                plan[i].ki = m_ki[plan[i].ch];
            end
            if (plan[i].ok && (plan[i].s + plan[i].lat == cyc)) plan[i].res = pid_out;
            if (!plan[i].ok && (plan[i].s + TMO - 1 == cyc)) m_fault[plan[i].ch] = 1'b1;
        end
        busy_now = (cyc >= m_lo) && (cyc <= m_hi);
        if (tick && busy_now) m_ovr = 1'b1;
        if (err_clr) begin
            m_ovr   = 1'b0;
            m_fault = '0;
        end
        if (tick && !busy_now && (ch_en != '0)) begin
            plan.delete();
            s = cyc + 3;
            for (int c = 0; c < NCH; c++) begin
                if (ch_en[c]) begin
                    plan_t p;
                    lat   = rand_mode ? pick_lat() : lat_tab[c];
                    p.ch  = c;
                    p.s   = s;
                    p.lat = lat;
                    p.ok  = (lat < TMO);
                    p.w   = p.ok ? lat + 1 : TMO;
                    p.rv  = '0; p.mv = '0; p.kp = '0; p.ki = '0; p.res = '0;
                    plan.push_back(p);
                    s = s + p.w + 2;
                end
            end
            m_lo = cyc + 1;
            m_hi = s - 2;
        end
        if (cfg_we && (int'(cfg_ch) < NCH)) begin
            m_kp[cfg_ch] = cfg_kp;
            m_ki[cfg_ch] = cfg_ki;
        end
        last_tick = tick;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_tick();
        do step(); while (!last_tick);
    endtask

    initial begin
        rst_drv = 1; rand_mode = 0; fix_ref = 0; race_mode = 0; done_force = 0;
        err_drv = 0; wr_drv = 0; last_tick = 0; en_drv = '0;
        lat_tab = '{2, 2, 2, 2};
        wr_ch = '0; wr_kp = '0; wr_ki = '0; race_kp = '0; race_ki = '0;
        model_reset();
        run(3);
        rst_drv = 0;

        // Scan of ch0, ch1, ch3 with a 2-cycle core.
        en_drv = 4'b1011;
        to_tick();

        // Gain routing for ch2.
        wr_ch = 2; wr_kp = DW'(5); wr_ki = DW'(-3); wr_drv = 1;
        step();
        wr_drv = 0;
        fix_ref = 1; en_drv = 4'b0100; lat_tab = '{3, 3, 3, 3};
        to_tick();
        run(20);
        fix_ref = 0;

        // ch1 never completes; then clear the fault.
        en_drv = 4'b1011; lat_tab = '{2, TMO + 4, 2, TMO - 1};
        to_tick();
        run(30);
        err_drv = 1; step(); err_drv = 0;

        // Gain write racing the ch0 issue, then a scan that sees the new gains.
        en_drv = 4'b0001; lat_tab = '{2, 2, 2, 2};
        race_kp = DW'(17); race_ki = DW'(-9); race_mode = 1;
        to_tick();
        race_mode = 0;
        to_tick();

        // Reset during WAIT with a late done, then a scan showing cleared gains.
        en_drv = 4'b1111; lat_tab = '{8, 8, 8, 8};
        to_tick();
        run(5);
        rst_drv = 1; step();
        done_force = 1; step();
        rst_drv = 0; step();
        done_force = 0;
        lat_tab = '{2, 0, 1, 2};
        to_tick();

        // Slow core overruns the next tick.
        lat_tab = '{10, 10, 10, 10};
        to_tick();
        to_tick();
        run(30);
        err_drv = 1; step(); err_drv = 0;

        // Randomized traffic.
        rand_mode = 1;
        repeat (15) to_tick();
        run(25);
        rand_mode = 0;
        run(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
